// File: rtl/mux_tree_pkg.sv
// Package: mux_tree_pkg
// Shared constants, the per-stage control struct and the level-count helper
// for the pipelined radix-4 mux tree (mux_tree_pipe).
package mux_tree_pkg;

  localparam int unsigned MAX_N_IN  = 256;
  localparam int unsigned RADIX     = 4;
  localparam int unsigned MAX_SEL_W = $clog2(MAX_N_IN);

  // Control travelling with each beat. sel is sized for the largest tree; narrower
  // trees zero-extend and only read their own low bits.
  typedef struct packed {
    logic                 valid;
    logic [MAX_SEL_W-1:0] sel;
  } stage_ctrl_t;

  // Number of radix-4 levels needed for n channels (an odd select width ends in radix-2).
  function automatic int unsigned clog4(input int unsigned n);
    return (32'($clog2(n)) + 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// Module: mux_tree_stage
// One registered reduction level of the mux tree. Groups of RADIX_K adjacent input
// channels are reduced to one channel using sel[SEL_LSB +: log2(RADIX_K)]; the result,
// the stage valid and the full select are registered together.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   data_i          N_CH flattened channels from the previous level
//   ctrl_i          {valid, sel} of the beat offered by the previous level
//   ready_o         this stage can load (empty, or downstream is taking its beat)
//   data_o          N_CH/RADIX_K registered channels
//   ctrl_o          registered {valid, sel}
//   ready_i         downstream ready
module mux_tree_stage
  import mux_tree_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_CH    = 16,
  parameter int unsigned RADIX_K = RADIX,
  parameter int unsigned SEL_LSB = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_CH*DATA_W-1:0]            data_i,
  input  stage_ctrl_t                       ctrl_i,
  output logic                              ready_o,
  output logic [(N_CH/RADIX_K)*DATA_W-1:0]  data_o,
  output stage_ctrl_t                       ctrl_o,
  input  logic                              ready_i
);

  localparam int unsigned N_OUT = N_CH / RADIX_K;
  localparam int unsigned SW    = (RADIX_K == 4) ? 2 : 1;

  logic [SW-1:0]           grp_sel;
  logic [N_OUT*DATA_W-1:0] red;
  logic [N_OUT*DATA_W-1:0] data_d, data_q;
  stage_ctrl_t             ctrl_d, ctrl_q;

  assign grp_sel = ctrl_i.sel[SEL_LSB +: SW];

  always_comb begin
    red = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      red[j*DATA_W +: DATA_W] = data_i[(j*RADIX_K + 32'(grp_sel))*DATA_W +: DATA_W];
    end
  end

  assign ready_o = !ctrl_q.valid || ready_i;

  // Bubbles keep stale data/sel; only the valid bit is cleared when nothing arrives.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (ready_o) begin
      ctrl_d.valid = ctrl_i.valid;
      if (ctrl_i.valid) begin
        ctrl_d.sel = ctrl_i.sel;
        data_d     = red;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Module: mux_tree_pipe
// Pipelined N_IN:1 multiplexer built from radix-4 levels (last level radix-2 when the
// select width is odd), one register stage per level, with valid/ready back-pressure.
// The select rides with its data, so latency is LEVELS cycles at one beat per cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_data        N_IN flattened channels, channel i at [i*DATA_W +: DATA_W]
//   in_sel         channel index, sampled with in_data
//   in_valid       input beat valid
//   in_ready       combinational ready chain through all stages (no skid buffer)
//   out_data       selected channel (registered)
//   out_sel        select that produced out_data
//   out_valid      output beat valid
//   out_ready      consumer accepts the beat
//   out_parity     XOR of the selected channel; only with MUX_TREE_PIPE_PARITY_EN defined
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned N_IN   = 16,
  localparam int unsigned SEL_W  = $clog2(N_IN),
  localparam int unsigned LEVELS = clog4(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef MUX_TREE_PIPE_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

`ifdef MUX_TREE_PIPE_PARITY_EN
  // Parity is attached to every channel up front and muxed like an extra data bit.
  localparam int unsigned CH_W = DATA_W + 1;
`else
  localparam int unsigned CH_W = DATA_W;
`endif

  logic [N_IN*CH_W-1:0] chan;
  stage_ctrl_t          ctrl_in;
  stage_ctrl_t          ctrl_out [LEVELS];
  logic                 ready    [LEVELS+1];
  logic                 unused_sel;

  always_comb begin
    chan = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
`ifdef MUX_TREE_PIPE_PARITY_EN
      chan[i*CH_W +: CH_W] = {^in_data[i*DATA_W +: DATA_W], in_data[i*DATA_W +: DATA_W]};
`else
      chan[i*CH_W +: CH_W] = in_data[i*DATA_W +: DATA_W];
`endif
    end
  end

  always_comb begin
    ctrl_in                = '0;
    ctrl_in.valid          = in_valid;
    ctrl_in.sel[SEL_W-1:0] = in_sel;
  end

  assign ready[LEVELS] = out_ready;
  assign in_ready      = ready[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NCH  = N_IN >> (2 * k);
    localparam int unsigned RDX  = (NCH >= RADIX) ? RADIX : 2;
    localparam int unsigned NOUT = NCH / RDX;

    logic [NCH*CH_W-1:0]  d_in;
    logic [NOUT*CH_W-1:0] d_out;
    stage_ctrl_t          c_in;

    if (k == 0) begin : g_head
      assign d_in = chan;
      assign c_in = ctrl_in;
    end else begin : g_body
      assign d_in = g_lvl[k-1].d_out;
      assign c_in = ctrl_out[k-1];
    end

    mux_tree_stage #(
      .DATA_W  (CH_W),
      .N_CH    (NCH),
      .RADIX_K (RDX),
      .SEL_LSB (2 * k)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .data_i  (d_in),
      .ctrl_i  (c_in),
      .ready_o (ready[k]),
      .data_o  (d_out),
      .ctrl_o  (ctrl_out[k]),
      .ready_i (ready[k+1])
    );

    if (k == LEVELS - 1) begin : g_tail
      assign out_data = d_out[DATA_W-1:0];
`ifdef MUX_TREE_PIPE_PARITY_EN
      assign out_parity = d_out[DATA_W];
`endif
    end
  end

  assign out_valid  = ctrl_out[LEVELS-1].valid;
  assign out_sel    = ctrl_out[LEVELS-1].sel[SEL_W-1:0];
  assign unused_sel = ^ctrl_out[LEVELS-1].sel;

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer tree built from radix-4 levels, with one register stage per level.
- Generalises the 2:1 / 4:1 / 16:1 hierarchy to:
  - arbitrary data width;
  - any power-of-two input count;
  - a valid/ready handshake with full back-pressure.
- Sits between wide multi-channel sources and a single consumer.
- The select travels with its data, so back-to-back selects on different channels sustain one result per cycle.

Parameters:
- DATA_W, 8: width of each input channel and of the output.
- N_IN, 16: number of input channels; power of two, 2..256.
- SEL_W, $clog2(N_IN): select width (derived; not to be overridden).
- LEVELS, (SEL_W+1)/2: number of radix-4 levels = pipeline depth (derived). If SEL_W is odd, the last level is radix-2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N_IN*DATA_W  flattened channels; channel i occupies bits [i*DATA_W +: DATA_W].
- in_sel  in  SEL_W  channel index, sampled with in_data.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  DATA_W  selected channel (registered).
- out_sel  out  SEL_W  select that produced out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, out_data, out_sel cleared to 0. In-flight beats are discarded, not flushed.
- Level k (k = 0..LEVELS-1):
  - consumes sel bits [2k+1:2k], LSBs first, matching the existing tree order;
  - reduces groups of 4 (or 2 on an odd final level) into a registered vector of N_IN/4^(k+1) channels;
  - registers its own stage valid;
  - forwards the full original sel to the next stage for out_sel.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage k loads when ready_k = !valid_k || ready_(k+1); ready_LEVELS = out_ready.
- in_ready = ready_0, a combinational chain; no skid buffer. Throughput is 1 beat/cycle while out_ready is high.
- Latency: exactly LEVELS cycles from the input transfer to out_valid. With N_IN=16 that is 2 cycles.
- Stall (out_ready low with out_valid high):
  - out_data, out_sel, out_valid hold stable;
  - bubbles upstream still fill; in_ready goes low only when every stage is valid.
- Simultaneous output transfer and input acceptance in the same cycle is legal; no beat is lost or duplicated.
- in_valid low: stages drain normally; bubble registers keep stale data, but out_data is guaranteed only while out_valid is high.
- in_sel and in_data are don't-care when in_valid is low.
- Every SEL_W value is a legal channel, so there is no out-of-range case.
- N_IN=2: LEVELS=1, single radix-2 stage.

Optional Feature:
- Macro: MUX_TREE_PIPE_PARITY_EN.
- Defined:
  - adds output port out_parity (1 bit), the even parity (XOR reduction) of the selected channel;
  - parity is computed at input acceptance and pipelined alongside, so it is aligned with out_data;
  - reset value 0;
  - holds under stall like out_data.
- Undefined: port absent, no parity logic. All other behaviour identical.

Decomposition:
- Package mux_tree_pkg:
  - function clog4 (levels from N_IN);
  - localparams MAX_N_IN=256 and RADIX=4;
  - typedef for the per-stage control struct {valid, sel}.
- One natural sub-module: mux_tree_stage.
  - Parameters: DATA_W, number of input channels, radix.
  - Contains one reduction level plus its data/valid/sel registers and ready logic.
  - Instantiated LEVELS times via generate.

Test Plan:
- Reset mid-stream:
  - Setup: N_IN=16, DATA_W=8, in_data channel i = 8'h10+i, in_sel=4'd5, in_valid held high, out_ready=1.
  - Action: assert rst_n low asynchronously between clock edges while beats are in flight.
  - Required: out_valid, out_data, out_sel = 0 immediately.
  - After release: the first output is 8'h15 exactly 2 cycles after the first input transfer.
- Streaming sweep:
  - Stimulus: in_sel = 0,1,...,15 on consecutive cycles, out_ready=1.
  - Required: out_data = 8'h10..8'h1F on consecutive cycles, out_sel matching each, no bubbles.
- Back-pressure:
  - Stimulus: stream sel 3,7,11,15 and drop out_ready for 4 cycles after the first output.
  - Required: out_data holds 8'h13; in_ready falls only once both stages are full; after release, 8'h17, 8'h1B, 8'h1F follow in order, none lost or duplicated.
- Odd level count:
  - Config: N_IN=8 (LEVELS=2, final radix-2), channel i = 8'hA0+i.
  - Stimulus: sel=6.
  - Required: out_data = 8'hA6 after 2 cycles.
- Parity (MUX_TREE_PIPE_PARITY_EN defined):
  - sel selecting 8'h07 -> out_parity = 1.
  - sel selecting 8'h03 -> out_parity = 0, aligned with out_valid.
- Random:
  - Stimulus: random in_valid/out_ready/sel for 10k cycles, with N_IN in {2, 4, 32}.
  - Required: scoreboard shows in-order, lossless delivery and the correct channel data for every beat.
